// File: rtl/pipelined_alu.sv
// Registered Beta-ALUFN ALU with valid/ready handshake, one-cycle latency and output hold.
// Define PIPELINED_ALU_MUL_EN to add the multi-cycle unsigned shift-add multiplier (MUL 000010).
module pipelined_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alufn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             illegal,
    output logic             busy
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b011000;
    localparam logic [5:0] OP_OR    = 6'b011110;
    localparam logic [5:0] OP_XOR   = 6'b010110;
    localparam logic [5:0] OP_A     = 6'b011010;
    localparam logic [5:0] OP_SHL   = 6'b100000;
    localparam logic [5:0] OP_SHR   = 6'b100001;
    localparam logic [5:0] OP_SRA   = 6'b100011;
    localparam logic [5:0] OP_CMPEQ = 6'b110011;
    localparam logic [5:0] OP_CMPLT = 6'b110101;
    localparam logic [5:0] OP_CMPLE = 6'b110111;
`ifdef PIPELINED_ALU_MUL_EN
    localparam logic [5:0] OP_MUL   = 6'b000010;
`endif

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             v;
        logic             n;
        logic             ill;
    } alu_t;

    // Single adder serves ADD, SUB and all compares; compares keep the a-b flags.
    function automatic alu_t alu_eval(input logic [5:0] fn,
                                      input logic signed [WIDTH-1:0] a_s,
                                      input logic signed [WIDTH-1:0] b_s);
        alu_t                    r;
        logic                    sub;
        logic                    adder_op;
        logic                    lt;
        logic signed [WIDTH-1:0] bx;
        logic signed [WIDTH-1:0] s;
        logic                    sz;
        logic                    sv;
        logic [SHW-1:0]          amt;
        r        = '0;
        adder_op = 1'b0;
        sub      = (fn != OP_ADD);
        bx       = sub ? ~b_s : b_s;
        s        = a_s + bx + {{(WIDTH-1){1'b0}}, sub};
        sz       = (s == '0);
        sv       = (a_s[WIDTH-1] == bx[WIDTH-1]) && (s[WIDTH-1] != a_s[WIDTH-1]);
        lt       = s[WIDTH-1] ^ sv;
        amt      = b_s[SHW-1:0];
        case (fn)
            OP_ADD, OP_SUB: begin r.res = s;                                 adder_op = 1'b1; end
            OP_CMPEQ:       begin r.res = {{(WIDTH-1){1'b0}}, sz};           adder_op = 1'b1; end
            OP_CMPLT:       begin r.res = {{(WIDTH-1){1'b0}}, lt};           adder_op = 1'b1; end
            OP_CMPLE:       begin r.res = {{(WIDTH-1){1'b0}}, lt | sz};      adder_op = 1'b1; end
            OP_AND:         r.res = a_s & b_s;
            OP_OR:          r.res = a_s | b_s;
            OP_XOR:         r.res = a_s ^ b_s;
            OP_A:           r.res = a_s;
            OP_SHL:         r.res = $unsigned(a_s) << amt;
            OP_SHR:         r.res = $unsigned(a_s) >> amt;
            OP_SRA:         r.res = $unsigned(a_s >>> amt);
            default:        r.ill = 1'b1;
        endcase
        if (adder_op) begin
            r.z = sz;
            r.v = sv;
            r.n = s[WIDTH-1];
        end else begin
            r.z = (r.res == '0);
            r.v = 1'b0;
            r.n = r.res[WIDTH-1];
        end
        return r;
    endfunction

    state_t state;
    alu_t   res_p0;
    logic   accept;

    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign res_p0   = alu_eval(alufn, $signed(a), $signed(b));

`ifdef PIPELINED_ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [SHW-1:0]     mul_cnt;

    assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`else
    assign busy = 1'b0;
`endif

    // Stage p0 -> p1: operation evaluated at accept, registered onto the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            z         <= 1'b0;
            v         <= 1'b0;
            n         <= 1'b0;
            illegal   <= 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
            busy       <= 1'b0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
`ifdef PIPELINED_ALU_MUL_EN
                        if (alufn == OP_MUL) begin
                            state      <= MUL;
                            busy       <= 1'b1;
                            out_valid  <= 1'b0;
                            mul_mcand  <= {{WIDTH{1'b0}}, a};
                            mul_mplier <= b;
                            mul_acc    <= '0;
                            mul_cnt    <= '0;
                        end else
`endif
                        begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            result    <= res_p0.res;
                            z         <= res_p0.z;
                            v         <= res_p0.v;
                            n         <= res_p0.n;
                            illegal   <= res_p0.ill;
                        end
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef PIPELINED_ALU_MUL_EN
                // One shift-add step per cycle; the last step writes the outputs directly.
                MUL: begin
                    mul_acc    <= mul_acc_nxt;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 1'b1;
                    if (mul_cnt == SHW'(WIDTH-1)) begin
                        state     <= HOLD;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= mul_acc_nxt[WIDTH-1:0];
                        z         <= (mul_acc_nxt[WIDTH-1:0] == '0);
                        v         <= |mul_acc_nxt[2*WIDTH-1:WIDTH];
                        n         <= mul_acc_nxt[WIDTH-1];
                        illegal   <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
